// File: rtl/pcie_rx_credit_return_if.sv
// pcie_rx_credit_return_if: VC0 receive stream from the core plus credit return/status back to it
interface pcie_rx_credit_return_if;
    logic [15:0] rx_data_vc0;
    logic        rx_st_vc0, rx_end_vc0, rx_us_req_vc0, rx_malf_tlp_vc0, tlp_release;
    logic        ph_processed_vc0, nph_processed_vc0, pd_processed_vc0, npd_processed_vc0;
    logic [7:0]  pd_num_vc0, npd_num_vc0;
    logic        ph_buf_status_vc0, pd_buf_status_vc0, nph_buf_status_vc0, npd_buf_status_vc0;
    modport master (
        output rx_data_vc0, rx_st_vc0, rx_end_vc0, rx_us_req_vc0, rx_malf_tlp_vc0, tlp_release,
        input  ph_processed_vc0, nph_processed_vc0, pd_processed_vc0, npd_processed_vc0,
        input  pd_num_vc0, npd_num_vc0,
        input  ph_buf_status_vc0, pd_buf_status_vc0, nph_buf_status_vc0, npd_buf_status_vc0
    );
    modport slave (
        input  rx_data_vc0, rx_st_vc0, rx_end_vc0, rx_us_req_vc0, rx_malf_tlp_vc0, tlp_release,
        output ph_processed_vc0, nph_processed_vc0, pd_processed_vc0, npd_processed_vc0,
        output pd_num_vc0, npd_num_vc0,
        output ph_buf_status_vc0, pd_buf_status_vc0, nph_buf_status_vc0, npd_buf_status_vc0
    );
endinterface

// File: rtl/pcie_rx_credit_return.sv
// pcie_rx_credit_return: classifies VC0 RX TLPs, queues consumed credits and returns them in order
module pcie_rx_credit_return #(
    parameter int QDEPTH    = 8,
    parameter int PH_LIMIT  = 16,
    parameter int PD_LIMIT  = 256,
    parameter int NPH_LIMIT = 8,
    parameter int MPS_CR    = 32
) (
    input  logic                    sys_clk_125,
    input  logic                    rst_n,
    pcie_rx_credit_return_if.slave  rx,
    output logic [$clog2(QDEPTH):0] crq_count,
    output logic                    crq_ovf
);
    localparam int AW = $clog2(QDEPTH);
    localparam int NW = AW + 1;
    localparam int CW = AW + 9;
    typedef enum logic [1:0] {P_IDLE, P_W1, P_BODY} parse_t;
    typedef enum logic [1:0] {R_IDLE, R_EMIT, R_EMIT2} rel_t;
    parse_t pst;
    rel_t rel_st;
    logic fmt1, cur_np, cur_big, is_p, is_np, push, pin, pop, full, hnp, hauto, e2, qa;
    logic [4:0] typ;
    logic [9:0] len;
    logic [8:0] dcr, hdcr;
    logic [7:0] hnum;
    logic [10:0] mem [QDEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt_n;
    logic [CW-1:0] ph_out, pd_out, nph_out, npd_out, ph_n, pd_n, nph_n, npd_n;
    always_comb begin
        is_p  = (typ == 5'b00000 && fmt1) || typ[4:3] == 2'b10;
        is_np = (typ[4:1] == 4'b0000 && !fmt1) || typ == 5'b00010 || typ[4:1] == 4'b0010;
        dcr   = !fmt1 ? 9'd0 : is_np ? 9'd1 : len == 10'd0 ? 9'd256 : 9'((11'(len) + 11'd3) >> 2);
        push  = pst == P_BODY && rx.rx_end_vc0 && !rx.rx_st_vc0 && (is_p || is_np);
        full  = crq_count == NW'(QDEPTH);
        pin   = push && !full;
        {hnp, hdcr, hauto} = mem[rp];
        hnum  = hdcr[8] ? 8'd255 : hdcr[7:0];
        // a 256-credit entry needs a second data pulse, so the head waits one cycle
        e2    = rel_st == R_EMIT && cur_big;
        pop   = crq_count != '0 && (hauto || rx.tlp_release) && !e2;
        cnt_n = crq_count + NW'(pin) - NW'(pop);
        ph_n  = ph_out + CW'(pin && is_p) - CW'(pop && !hnp);
        nph_n = nph_out + CW'(pin && is_np) - CW'(pop && hnp);
        pd_n  = pd_out + (pin && is_p ? CW'(dcr) : '0) - (pop && !hnp ? CW'(hdcr) : '0);
        npd_n = npd_out + (pin && is_np ? CW'(dcr) : '0) - (pop && hnp ? CW'(hdcr) : '0);
        qa    = cnt_n >= NW'(QDEPTH - 1);
    end
    always_ff @(posedge sys_clk_125)
        if (pin) mem[wp] <= {is_np, dcr, rx.rx_us_req_vc0 | rx.rx_malf_tlp_vc0};
    always_ff @(posedge sys_clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            pst <= P_IDLE;
            rel_st <= R_IDLE;
            fmt1 <= 1'b0;
            typ <= '0;
            len <= '0;
            wp <= '0;
            rp <= '0;
            cur_np <= 1'b0;
            cur_big <= 1'b0;
            crq_count <= '0;
            crq_ovf <= 1'b0;
            ph_out <= '0;
            pd_out <= '0;
            nph_out <= '0;
            npd_out <= '0;
            rx.ph_processed_vc0 <= 1'b0;
            rx.nph_processed_vc0 <= 1'b0;
            rx.pd_processed_vc0 <= 1'b0;
            rx.npd_processed_vc0 <= 1'b0;
            rx.pd_num_vc0 <= '0;
            rx.npd_num_vc0 <= '0;
            rx.ph_buf_status_vc0 <= 1'b0;
            rx.pd_buf_status_vc0 <= 1'b0;
            rx.nph_buf_status_vc0 <= 1'b0;
            rx.npd_buf_status_vc0 <= 1'b0;
        end else begin
            pst <= rx.rx_st_vc0 ? P_W1 : pst == P_W1 ? P_BODY : pst == P_BODY && rx.rx_end_vc0 ? P_IDLE : pst;
            if (rx.rx_st_vc0) {fmt1, typ} <= {rx.rx_data_vc0[14], rx.rx_data_vc0[12:8]};
            if (pst == P_W1 && !rx.rx_st_vc0) len <= rx.rx_data_vc0[9:0];
            if (pin) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (pop) {cur_np, cur_big} <= {hnp, hdcr[8]};
            rel_st <= pop ? R_EMIT : e2 ? R_EMIT2 : R_IDLE;
            crq_count <= cnt_n;
            crq_ovf <= crq_ovf | (push && full);
            {ph_out, pd_out, nph_out, npd_out} <= {ph_n, pd_n, nph_n, npd_n};
            rx.ph_processed_vc0 <= pop && !hnp;
            rx.nph_processed_vc0 <= pop && hnp;
            rx.pd_processed_vc0 <= pop ? !hnp && hdcr != '0 : e2 && !cur_np;
            rx.npd_processed_vc0 <= pop ? hnp && hdcr != '0 : e2 && cur_np;
            rx.pd_num_vc0 <= pop && !hnp ? hnum : e2 && !cur_np ? 8'd1 : 8'd0;
            rx.npd_num_vc0 <= pop && hnp ? hnum : e2 && cur_np ? 8'd1 : 8'd0;
            rx.ph_buf_status_vc0 <= ph_n >= CW'(PH_LIMIT - 2) || qa;
            rx.pd_buf_status_vc0 <= pd_n >= CW'(PD_LIMIT - MPS_CR) || qa;
            rx.nph_buf_status_vc0 <= nph_n >= CW'(NPH_LIMIT - 2) || qa;
            rx.npd_buf_status_vc0 <= npd_n >= CW'(NPH_LIMIT - 2) || qa;
        end
    end
endmodule

// File: tb/tb_pcie_rx_credit_return.sv
// tb_pcie_rx_credit_return: directed TLP stimulus checked against a queue-based credit model
module tb_pcie_rx_credit_return;
    localparam int QDEPTH = 8, PH_LIMIT = 16, PD_LIMIT = 256, NPH_LIMIT = 8, MPS_CR = 32;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] crq_count;
    logic crq_ovf;
    int n_cmp = 0, n_bad = 0;
    pcie_rx_credit_return_if bus();
    pcie_rx_credit_return #(.QDEPTH(QDEPTH), .PH_LIMIT(PH_LIMIT), .PD_LIMIT(PD_LIMIT),
        .NPH_LIMIT(NPH_LIMIT), .MPS_CR(MPS_CR)) dut (
        .sys_clk_125(clk), .rst_n(rst_n), .rx(bus), .crq_count(crq_count), .crq_ovf(crq_ovf));
    always #5 clk = ~clk;

    typedef struct {bit np; int dcr; bit au;} ent_t;
    ent_t q[$];
    ent_t h, nw;
    int widx = 0, sz = 0, m_ph = 0, m_pd = 0, m_nph = 0, m_npd = 0, ln = 0;
    logic [15:0] w0 = '0, w1 = '0;
    logic [4:0] t = '0;
    bit have = 0, post = 0, np = 0, pop_now = 0, m_e2 = 0, m_e2np = 0, m_ovf = 0, c7 = 0;
    logic [3:0] e_pulse = '0, e_stat = '0;
    logic [7:0] e_pdn = '0, e_npdn = '0;

    function automatic logic [7:0] sat(input int d);
        return d > 255 ? 8'd255 : 8'(d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            widx = 0; m_ph = 0; m_pd = 0; m_nph = 0; m_npd = 0;
            m_e2 = 0; m_ovf = 0; e_pulse = '0; e_stat = '0; e_pdn = '0; e_npdn = '0;
        end else begin
            sz = q.size();
            have = 0;
            if (bus.rx_st_vc0) begin widx = 1; w0 = bus.rx_data_vc0; end
            else if (widx == 1) begin w1 = bus.rx_data_vc0; widx = 2; end
            else if (widx == 2 && bus.rx_end_vc0) begin
                widx = 0;
                t = w0[12:8];
                ln = int'(w1[9:0]);
                post = (t == 5'd0 && w0[14]) || t[4:3] == 2'b10;
                np = (t <= 5'd1 && !w0[14]) || t == 5'd2 || t == 5'd4 || t == 5'd5;
                have = post || np;
                nw.np = np;
                nw.dcr = !w0[14] ? 0 : np ? 1 : ln == 0 ? 256 : (ln + 3) / 4;
                nw.au = bus.rx_us_req_vc0 | bus.rx_malf_tlp_vc0;
            end
            pop_now = sz > 0 && (q[0].au || bus.tlp_release) && !m_e2;
            e_pulse = '0; e_pdn = '0; e_npdn = '0;
            if (m_e2) begin
                if (m_e2np) begin e_pulse[0] = 1; e_npdn = 8'd1; end
                else begin e_pulse[1] = 1; e_pdn = 8'd1; end
            end
            m_e2 = 0;
            if (pop_now) begin
                h = q.pop_front();
                e_pulse[3] = !h.np;
                e_pulse[2] = h.np;
                if (h.dcr > 0) begin
                    if (h.np) begin e_pulse[0] = 1; e_npdn = sat(h.dcr); end
                    else begin e_pulse[1] = 1; e_pdn = sat(h.dcr); end
                end
                m_e2 = h.dcr == 256;
                m_e2np = h.np;
                if (h.np) begin m_nph--; m_npd -= h.dcr; end else begin m_ph--; m_pd -= h.dcr; end
            end
            if (have) begin
                if (sz >= QDEPTH) m_ovf = 1;
                else begin
                    q.push_back(nw);
                    if (nw.np) begin m_nph++; m_npd += nw.dcr; end else begin m_ph++; m_pd += nw.dcr; end
                end
            end
            c7 = q.size() >= QDEPTH - 1;
            e_stat = {m_ph >= PH_LIMIT - 2 || c7, m_pd >= PD_LIMIT - MPS_CR || c7,
                      m_nph >= NPH_LIMIT - 2 || c7, m_npd >= NPH_LIMIT - 2 || c7};
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pulses", 16'({bus.ph_processed_vc0, bus.nph_processed_vc0, bus.pd_processed_vc0, bus.npd_processed_vc0}), 16'(e_pulse));
        chk("pd_num", 16'(bus.pd_num_vc0), 16'(e_pdn));
        chk("npd_num", 16'(bus.npd_num_vc0), 16'(e_npdn));
        chk("crq_count", 16'(crq_count), 16'(q.size()));
        chk("buf_status", 16'({bus.ph_buf_status_vc0, bus.pd_buf_status_vc0, bus.nph_buf_status_vc0, bus.npd_buf_status_vc0}), 16'(e_stat));
        chk("crq_ovf", 16'(crq_ovf), 16'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input int n, input bit us, input bit malf, input bit fin);
        for (int i = 0; i < n; i++) begin
            bus.rx_st_vc0 = i == 0;
            bus.rx_end_vc0 = fin && i == n - 1;
            bus.rx_data_vc0 = i == 0 ? a : i == 1 ? b : 16'($urandom);
            bus.rx_us_req_vc0 = us && bus.rx_end_vc0;
            bus.rx_malf_tlp_vc0 = malf && bus.rx_end_vc0;
            tick();
        end
        {bus.rx_st_vc0, bus.rx_end_vc0, bus.rx_us_req_vc0, bus.rx_malf_tlp_vc0} = '0;
    endtask

    task automatic rel(input int n);
        bus.tlp_release = 1'b1;
        repeat (n) tick();
        bus.tlp_release = 1'b0;
    endtask

    function automatic logic [3:0] pulses();
        return {bus.ph_processed_vc0, bus.nph_processed_vc0, bus.pd_processed_vc0, bus.npd_processed_vc0};
    endfunction

    initial begin
        {bus.rx_st_vc0, bus.rx_end_vc0, bus.rx_us_req_vc0, bus.rx_malf_tlp_vc0, bus.tlp_release} = '0;
        bus.rx_data_vc0 = '0;
        repeat (3) tick();
        chk("reset_pulses", 16'(pulses()), 16'h0);
        chk("reset_count", 16'(crq_count), 16'h0);
        chk("reset_ovf", 16'(crq_ovf), 16'h0);
        rst_n = 1'b1;
        tick();
        // MWr 3DW, 16 DW payload
        send(16'h4000, 16'h0010, 6, 0, 0, 1);
        chk("mwr16_count", 16'(crq_count), 16'd1);
        rel(1);
        chk("mwr16_pulses", 16'(pulses()), 16'b1010);
        chk("mwr16_pd_num", 16'(bus.pd_num_vc0), 16'd4);
        tick();
        chk("mwr16_after", 16'(pulses()), 16'h0);
        // MWr with length 0 -> 256 data credits
        send(16'h4000, 16'h0000, 6, 0, 0, 1);
        chk("mwr0_pd_status", 16'(bus.pd_buf_status_vc0), 16'd1);
        rel(1);
        chk("mwr0_emit_num", 16'(bus.pd_num_vc0), 16'd255);
        chk("mwr0_emit_pulses", 16'(pulses()), 16'b1010);
        tick();
        chk("mwr0_emit2_num", 16'(bus.pd_num_vc0), 16'd1);
        chk("mwr0_emit2_pulses", 16'(pulses()), 16'b0010);
        tick();
        chk("mwr0_done", 16'(pulses()), 16'h0);
        // CfgWr0 with unsupported request: auto return
        send(16'h4400, 16'h0001, 6, 1, 0, 1);
        chk("cfg_auto_wait", 16'(pulses()), 16'h0);
        tick();
        chk("cfg_auto_pulses", 16'(pulses()), 16'b0101);
        chk("cfg_auto_npd_num", 16'(bus.npd_num_vc0), 16'd1);
        // malformed MRd: auto header-only return
        send(16'h0000, 16'h0004, 6, 0, 1, 1);
        tick();
        chk("mrd_malf_pulses", 16'(pulses()), 16'b0100);
        // MRd, Cpl, MWr len 5
        send(16'h0000, 16'h0001, 6, 0, 0, 1);
        send(16'h0A00, 16'h0001, 6, 0, 0, 1);
        send(16'h4000, 16'h0005, 6, 0, 0, 1);
        chk("mix_count", 16'(crq_count), 16'd2);
        rel(1);
        chk("mix_nph", 16'(pulses()), 16'b0100);
        tick();
        rel(1);
        chk("mix_ph_pd", 16'(pulses()), 16'b1010);
        chk("mix_pd_num", 16'(bus.pd_num_vc0), 16'd2);
        // release with empty queue is ignored
        rel(1);
        chk("empty_release", 16'(pulses()), 16'h0);
        // QDEPTH+1 posted TLPs, no release
        for (int i = 0; i < QDEPTH + 1; i++) begin
            send(16'h4000, 16'h0001, 6, 0, 0, 1);
            if (i == QDEPTH - 3) chk("fill6_ph_status", 16'(bus.ph_buf_status_vc0), 16'd0);
            if (i == QDEPTH - 2) chk("fill7_ph_status", 16'(bus.ph_buf_status_vc0), 16'd1);
        end
        chk("fill_count", 16'(crq_count), 16'd8);
        chk("fill_ovf", 16'(crq_ovf), 16'd1);
        rel(QDEPTH);
        tick();
        chk("drain_count", 16'(crq_count), 16'd0);
        chk("drain_ovf_sticky", 16'(crq_ovf), 16'd1);
        // aborted TLP, then reset during EMIT2
        send(16'h4000, 16'h0003, 3, 0, 0, 0);
        send(16'h4000, 16'h0000, 6, 0, 0, 1);
        chk("abort_count", 16'(crq_count), 16'd1);
        rel(1);
        tick();
        chk("abort_emit2_num", 16'(bus.pd_num_vc0), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_pulses", 16'(pulses()), 16'h0);
        chk("rst_pd_num", 16'(bus.pd_num_vc0), 16'h0);
        chk("rst_ovf", 16'(crq_ovf), 16'h0);
        chk("rst_count", 16'(crq_count), 16'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_pulses", 16'(pulses()), 16'h0);
        chk("post_rst_status", 16'(bus.pd_buf_status_vc0), 16'h0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
